execute_unit: RTL and testbench

- Consumer end of the decode micro-op interface: accepts one decoded bundle per handshake and executes it. Bundle fields: uop, sel_p0/sel_p1/sel_in, num, num_to_rhs, branch_cond, explose.
- Owns the 8x32 low register file and the NZCV flags.
- Resolves branches for fetch.
- Drives a single-outstanding memory port for LDR/STR.
- Sits between decode and the data memory / fetch redirect logic.

---
 rtl/exec_pkg.sv | 37 +++
 rtl/cond_check.sv | 35 +++
 rtl/execute_unit.sv | 216 +++++++++++++++++++++
 tb/tb_execute_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: micro-op codes, branch conditions, FSM states.
package exec_pkg;

    localparam logic [4:0] UOP_NOP = 5'd0;
    localparam logic [4:0] UOP_ADD = 5'd1;
    localparam logic [4:0] UOP_SUB = 5'd2;
    localparam logic [4:0] UOP_EOR = 5'd4;
    localparam logic [4:0] UOP_CMP = 5'd5;
    localparam logic [4:0] UOP_LSL = 5'd6;
    localparam logic [4:0] UOP_MOV = 5'd8;
    localparam logic [4:0] UOP_STR = 5'd9;
    localparam logic [4:0] UOP_LDR = 5'd10;

    localparam logic [3:0] COND_EQ     = 4'b0000;
    localparam logic [3:0] COND_NE     = 4'b0001;
    localparam logic [3:0] COND_CS     = 4'b0010;
    localparam logic [3:0] COND_CC     = 4'b0011;
    localparam logic [3:0] COND_MI     = 4'b0100;
    localparam logic [3:0] COND_PL     = 4'b0101;
    localparam logic [3:0] COND_VS     = 4'b0110;
    localparam logic [3:0] COND_VC     = 4'b0111;
    localparam logic [3:0] COND_HI     = 4'b1000;
    localparam logic [3:0] COND_LS     = 4'b1001;
    localparam logic [3:0] COND_GE     = 4'b1010;
    localparam logic [3:0] COND_LT     = 4'b1011;
    localparam logic [3:0] COND_GT     = 4'b1100;
    localparam logic [3:0] COND_LE     = 4'b1101;
    localparam logic [3:0] COND_ALWAYS = 4'b1110;
    localparam logic [3:0] COND_NONE   = 4'b1111;

    typedef enum logic [1:0] {
        ST_EXEC = 2'd0,
        ST_MEM  = 2'd1,
        ST_TRAP = 2'd2
    } state_e;

endpackage

// File: rtl/cond_check.sv
// ARM-style condition evaluation on {N,Z,C,V}; COND_NONE never passes.
module cond_check
    import exec_pkg::*;
(
    input  logic [3:0] flags_i,
    input  logic [3:0] cond_i,
    output logic       pass_o
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags_i;

    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            COND_EQ:     pass_o = z;
            COND_NE:     pass_o = ~z;
            COND_CS:     pass_o = c;
            COND_CC:     pass_o = ~c;
            COND_MI:     pass_o = n;
            COND_PL:     pass_o = ~n;
            COND_VS:     pass_o = v;
            COND_VC:     pass_o = ~v;
            COND_HI:     pass_o = c & ~z;
            COND_LS:     pass_o = ~c | z;
            COND_GE:     pass_o = (n == v);
            COND_LT:     pass_o = (n != v);
            COND_GT:     pass_o = ~z & (n == v);
            COND_LE:     pass_o = z | (n != v);
            COND_ALWAYS: pass_o = 1'b1;
            default:     pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: 8x32 register file, NZCV flags, branch resolve, single-outstanding LDR/STR port.
//   state   | meaning
//   ST_EXEC | accepting bundles, ALU/branch ops complete in one cycle
//   ST_MEM  | load/store in flight, waiting for mem_ack or timeout
//   ST_TRAP | fault latched, bundles ignored until reset
module execute_unit
    import exec_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned LDST_SHIFT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  uop,
    input  logic        num_to_rhs,
    input  logic [31:0] num,
    input  logic [3:0]  sel_p0,
    input  logic [3:0]  sel_p1,
    input  logic [3:0]  sel_in,
    input  logic        explose,
    input  logic [3:0]  branch_cond,
    input  logic [31:0] pc,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  flags,
    output logic        retire,
    output logic        trap,
    input  logic [2:0]  dbg_sel,
    output logic [31:0] dbg_data
);

    localparam int unsigned TMR_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD =
        (MEM_TIMEOUT == 0) ? {TMR_W{1'b0}} : TMR_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [31:0]       regs_q [8];
    logic [3:0]        flags_q, flags_d;
    logic              retire_q, retire_d;
    logic              br_taken_q, br_taken_d;
    logic [31:0]       br_target_q, br_target_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic [2:0]        ld_dst_q, ld_dst_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic              wr_en;
    logic [2:0]        wr_idx;
    logic [31:0]       wr_data;

    logic [31:0]       lhs, rhs, br_off;
    logic [32:0]       sum_add, sum_sub, shl;
    logic              v_add, v_sub, shl_c, sel_bad, cond_pass;

    cond_check u_cond (
        .flags_i (flags_q),
        .cond_i  (branch_cond),
        .pass_o  (cond_pass)
    );

    assign lhs     = regs_q[sel_p1[2:0]];
    assign rhs     = num_to_rhs ? num : regs_q[sel_p0[2:0]];
    assign sel_bad = sel_p0[3] | sel_p1[3] | sel_in[3];

    assign sum_add = {1'b0, lhs} + {1'b0, rhs};
    assign sum_sub = {1'b0, lhs} + {1'b0, ~rhs} + 33'd1;
    assign shl     = {1'b0, lhs} << rhs[4:0];
    assign v_add   = (lhs[31] == rhs[31]) && (sum_add[31] != lhs[31]);
    assign v_sub   = (lhs[31] != rhs[31]) && (sum_sub[31] != lhs[31]);
    // A zero shift amount leaves carry alone rather than clearing it.
    assign shl_c   = (rhs[4:0] == 5'd0) ? flags_q[1] : shl[32];

    assign br_off  = (branch_cond == COND_ALWAYS) ? {{21{num[10]}}, num[10:0]}
                                                  : {{24{num[7]}}, num[7:0]};

    always_comb begin
        state_d     = state_q;
        flags_d     = flags_q;
        retire_d    = 1'b0;
        br_taken_d  = 1'b0;
        br_target_d = br_target_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        ld_dst_d    = ld_dst_q;
        timer_d     = timer_q;
        wr_en       = 1'b0;
        wr_idx      = sel_in[2:0];
        wr_data     = 32'd0;

        case (state_q)
            ST_EXEC: begin
                if (in_valid) begin
                    if (explose || sel_bad) begin
                        state_d = ST_TRAP;
                    end else begin
                        case (uop)
                            UOP_NOP: begin
                                retire_d = 1'b1;
                                if (branch_cond != COND_NONE && cond_pass) begin
                                    br_taken_d  = 1'b1;
                                    br_target_d = pc + 32'd4 + (br_off << 1);
                                end
                            end
                            UOP_ADD: begin
                                wr_en    = 1'b1;
                                wr_data  = sum_add[31:0];
                                retire_d = 1'b1;
                                flags_d  = {sum_add[31], sum_add[31:0] == 32'd0, sum_add[32], v_add};
                            end
                            UOP_SUB, UOP_CMP: begin
                                wr_en    = (uop == UOP_SUB);
                                wr_data  = sum_sub[31:0];
                                retire_d = 1'b1;
                                flags_d  = {sum_sub[31], sum_sub[31:0] == 32'd0, sum_sub[32], v_sub};
                            end
                            UOP_EOR: begin
                                wr_en    = 1'b1;
                                wr_data  = lhs ^ rhs;
                                retire_d = 1'b1;
                                flags_d  = {wr_data[31], wr_data == 32'd0, flags_q[1:0]};
                            end
                            UOP_LSL: begin
                                wr_en    = 1'b1;
                                wr_data  = shl[31:0];
                                retire_d = 1'b1;
                                flags_d  = {shl[31], shl[31:0] == 32'd0, shl_c, flags_q[0]};
                            end
                            UOP_MOV: begin
                                wr_en    = 1'b1;
                                wr_data  = rhs;
                                retire_d = 1'b1;
                                flags_d  = {rhs[31], rhs == 32'd0, flags_q[1:0]};
                            end
                            UOP_STR, UOP_LDR: begin
                                mem_addr_d  = lhs + (num << LDST_SHIFT);
                                mem_wdata_d = regs_q[sel_p0[2:0]];
                                mem_we_d    = (uop == UOP_STR);
                                ld_dst_d    = sel_in[2:0];
                                timer_d     = TMR_LOAD;
                                state_d     = ST_MEM;
                            end
                            default: state_d = ST_TRAP;
                        endcase
                    end
                end
            end
            ST_MEM: begin
                // Ack is tested first so it beats a timeout landing in the same cycle.
                if (mem_ack) begin
                    wr_en    = ~mem_we_q;
                    wr_idx   = ld_dst_q;
                    wr_data  = mem_rdata;
                    retire_d = 1'b1;
                    state_d  = ST_EXEC;
                end else if (MEM_TIMEOUT != 0 && timer_q == '0) begin
                    state_d = ST_TRAP;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EXEC;
            flags_q     <= 4'd0;
            retire_q    <= 1'b0;
            br_taken_q  <= 1'b0;
            br_target_q <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_we_q    <= 1'b0;
            ld_dst_q    <= 3'd0;
            timer_q     <= '0;
            for (int i = 0; i < 8; i++) regs_q[i] <= 32'd0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            retire_q    <= retire_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            ld_dst_q    <= ld_dst_d;
            timer_q     <= timer_d;
            if (wr_en) regs_q[wr_idx] <= wr_data;
        end
    end

    assign in_ready      = (state_q == ST_EXEC);
    assign trap          = (state_q == ST_TRAP);
    assign mem_req       = (state_q == ST_MEM);
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign flags         = flags_q;
    assign retire        = retire_q;
    assign branch_taken  = br_taken_q;
    assign branch_target = br_target_q;
    assign dbg_data      = regs_q[dbg_sel];

endmodule

// File: tb/tb_execute_unit.sv
// Directed and randomized checks of execute_unit against an arithmetic reference model.
`timescale 1ns/1ps
module tb_execute_unit;
    import exec_pkg::*;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        reset, in_valid, num_to_rhs, explose, mem_ack;
    logic [4:0]  uop;
    logic [31:0] num, pc, mem_rdata;
    logic [3:0]  sel_p0, sel_p1, sel_in, branch_cond;
    logic [2:0]  dbg_sel;
    logic        in_ready, branch_taken, mem_req, mem_we, retire, trap;
    logic [31:0] branch_target, mem_addr, mem_wdata, dbg_data;
    logic [3:0]  flags;

    always #5 clk = ~clk;

    execute_unit #(.MEM_TIMEOUT(TMO), .LDST_SHIFT(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .uop(uop), .num_to_rhs(num_to_rhs), .num(num), .sel_p0(sel_p0),
        .sel_p1(sel_p1), .sel_in(sel_in), .explose(explose),
        .branch_cond(branch_cond), .pc(pc), .branch_taken(branch_taken),
        .branch_target(branch_target), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .flags(flags), .retire(retire), .trap(trap),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    int n_chk = 0, n_pass = 0, n_fail = 0;
    logic [31:0] m_reg [8];
    logic [3:0]  m_flags;   // {N,Z,C,V}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 32'd0;
        m_flags = 4'd0;
    endtask

    function automatic logic cond_ok(input logic [3:0] c);
        logic n_, z_, c_, v_;
        {n_, z_, c_, v_} = m_flags;
        case (c)
            4'd0:  return z_;
            4'd1:  return !z_;
            4'd2:  return c_;
            4'd3:  return !c_;
            4'd4:  return n_;
            4'd5:  return !n_;
            4'd6:  return v_;
            4'd7:  return !v_;
            4'd8:  return c_ && !z_;
            4'd9:  return !c_ || z_;
            4'd10: return n_ == v_;
            4'd11: return n_ != v_;
            4'd12: return !z_ && (n_ == v_);
            4'd13: return z_ || (n_ != v_);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int br_off(input logic [3:0] c, input logic [31:0] n);
        int off;
        if (c == 4'd14) begin
            off = int'(n & 32'h7FF);
            if (off >= 1024) off -= 2048;
        end else begin
            off = int'(n & 32'hFF);
            if (off >= 128) off -= 256;
        end
        return off;
    endfunction

    task automatic model_alu(input logic [4:0] u, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] d);
        logic [31:0] res;
        logic [63:0] wide;
        logic        n_, z_, c_, v_;
        longint      sa, sb;
        int          sh;
        {n_, z_, c_, v_} = m_flags;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = 32'd0;
        case (u)
            UOP_ADD: begin
                wide = 64'(a) + 64'(b);
                res  = wide[31:0];
                c_   = wide[32];
                v_   = (sa + sb) != longint'($signed(res));
            end
            UOP_SUB, UOP_CMP: begin
                res = a - b;
                c_  = (a >= b);
                v_  = (sa - sb) != longint'($signed(res));
            end
            UOP_EOR: res = a ^ b;
            UOP_LSL: begin
                sh  = int'(b[4:0]);
                res = a << sh;
                if (sh != 0) c_ = a[32 - sh];
            end
            UOP_MOV: res = b;
            default: res = 32'd0;
        endcase
        n_ = res[31];
        z_ = (res == 32'd0);
        m_flags = {n_, z_, c_, v_};
        if (u != UOP_CMP) m_reg[d] = res;
    endtask

    task automatic set_bundle(input logic [4:0] u, input logic [3:0] d, input logic [3:0] p1,
                              input logic [3:0] p0, input logic nrhs, input logic [31:0] n,
                              input logic [3:0] cond, input logic [31:0] pcv);
        uop = u; sel_in = d; sel_p1 = p1; sel_p0 = p0;
        num_to_rhs = nrhs; num = n; branch_cond = cond; pc = pcv;
    endtask

    task automatic pulse();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i);
            #1;
            check($sformatf("%s r%0d", tag, i), dbg_data, m_reg[i]);
        end
    endtask

    task automatic op(input string tag, input logic [4:0] u, input logic [2:0] d,
                      input logic [2:0] p1, input logic [2:0] p0, input logic nrhs,
                      input logic [31:0] n, input logic [3:0] cond, input logic [31:0] pcv);
        logic [31:0] b, tgt;
        logic        take;
        b    = nrhs ? n : m_reg[p0];
        take = 1'b0;
        tgt  = 32'd0;
        if (u == UOP_NOP) begin
            if (cond != COND_NONE && cond_ok(cond)) begin
                take = 1'b1;
                tgt  = pcv + 32'd4 + 32'(br_off(cond, n) * 2);
            end
        end else begin
            model_alu(u, m_reg[p1], b, d);
        end
        set_bundle(u, {1'b0, d}, {1'b0, p1}, {1'b0, p0}, nrhs, n, cond, pcv);
        pulse();
        check({tag, " retire"}, 32'(retire), 32'd1);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " br_taken"}, 32'(branch_taken), 32'(take));
        if (take) check({tag, " br_target"}, branch_target, tgt);
        check({tag, " flags"}, 32'(flags), 32'(m_flags));
        dbg_sel = d;
        #1;
        check({tag, " dest"}, dbg_data, m_reg[d]);
    endtask

    task automatic memop(input string tag, input logic ldr, input logic [2:0] d,
                         input logic [2:0] p1, input logic [2:0] p0, input logic [31:0] n,
                         input int dly, input logic [31:0] rd);
        logic [31:0] ea, wd;
        ea = m_reg[p1] + (n << 2);
        wd = m_reg[p0];
        set_bundle(ldr ? UOP_LDR : UOP_STR, {1'b0, d}, {1'b0, p1}, {1'b0, p0},
                   1'($urandom_range(0, 1)), n, COND_NONE, 32'd0);
        pulse();
        check({tag, " req"}, 32'(mem_req), 32'd1);
        check({tag, " we"}, 32'(mem_we), 32'(!ldr));
        check({tag, " addr"}, mem_addr, ea);
        if (!ldr) check({tag, " wdata"}, mem_wdata, wd);
        check({tag, " busy"}, 32'(in_ready), 32'd0);
        for (int k = 0; k < dly; k++) begin
            in_valid = 1'b1;   // must be ignored while busy
            @(posedge clk); #1;
            in_valid = 1'b0;
            check({tag, " req hold"}, 32'(mem_req), 32'd1);
            check({tag, " addr hold"}, mem_addr, ea);
        end
        mem_ack = 1'b1;
        mem_rdata = rd;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        mem_rdata = $urandom();
        if (ldr) m_reg[d] = rd;
        check({tag, " retire"}, 32'(retire), 32'd1);
        check({tag, " req drop"}, 32'(mem_req), 32'd0);
        check({tag, " ready"}, 32'(in_ready), 32'd1);
        check({tag, " flags"}, 32'(flags), 32'(m_flags));
        dbg_sel = d;
        #1;
        check({tag, " dest"}, dbg_data, m_reg[d]);
    endtask

    logic [4:0] alu_ops [6];

    initial begin
        alu_ops = '{UOP_ADD, UOP_SUB, UOP_EOR, UOP_CMP, UOP_LSL, UOP_MOV};
        in_valid = 0; num_to_rhs = 0; explose = 0; mem_ack = 0; mem_rdata = 0;
        uop = 0; num = 0; pc = 0; sel_p0 = 0; sel_p1 = 0; sel_in = 0;
        branch_cond = COND_NONE; dbg_sel = 0; reset = 1;
        @(posedge clk); #1;
        do_reset();
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst trap", 32'(trap), 32'd0);
        check("rst mem_req", 32'(mem_req), 32'd0);
        check("rst retire", 32'(retire), 32'd0);
        check("rst br_taken", 32'(branch_taken), 32'd0);
        check("rst flags", 32'(flags), 32'd0);
        check_regs("rst");

        // Back-to-back ALU ops with forwarding through the register file.
        op("t1 mov", UOP_MOV, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5, COND_NONE, 32'd0);
        op("t1 add", UOP_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 32'd3, COND_NONE, 32'd0);
        dbg_sel = 3'd2; #1;
        check("t1 r2", dbg_data, 32'd8);

        op("t2 mov", UOP_MOV, 3'd0, 3'd0, 3'd0, 1'b1, 32'd0, COND_NONE, 32'd0);
        op("t2 sub", UOP_SUB, 3'd3, 3'd0, 3'd0, 1'b1, 32'd1, COND_NONE, 32'd0);
        check("t2 sub nzcv", 32'(flags), 32'b1000);
        op("t2 lsl", UOP_LSL, 3'd4, 3'd3, 3'd0, 1'b1, 32'd31, COND_NONE, 32'd0);
        dbg_sel = 3'd4; #1;
        check("t2 r4", dbg_data, 32'h8000_0000);
        check("t2 lsl c", 32'(flags[1]), 32'd1);
        op("t2 lsl0", UOP_LSL, 3'd5, 3'd4, 3'd0, 1'b1, 32'd0, COND_NONE, 32'd0);

        op("t3 mov", UOP_MOV, 3'd0, 3'd0, 3'd0, 1'b1, 32'd7, COND_NONE, 32'd0);
        op("t3 cmp", UOP_CMP, 3'd6, 3'd0, 3'd0, 1'b1, 32'd7, COND_NONE, 32'd0);
        op("t3 beq", UOP_NOP, 3'd0, 3'd0, 3'd0, 1'b1, 32'hFE, COND_EQ, 32'd100);
        check("t3 target", branch_target, 32'd100);
        op("t3 bne", UOP_NOP, 3'd0, 3'd0, 3'd0, 1'b1, 32'hFE, COND_NE, 32'd100);
        op("t3 bal", UOP_NOP, 3'd0, 3'd0, 3'd0, 1'b1, 32'h400, COND_ALWAYS, 32'h1000);
        op("t3 nop", UOP_NOP, 3'd7, 3'd0, 3'd0, 1'b1, 32'h0, COND_NONE, 32'h0);

        op("t4 mov", UOP_MOV, 3'd5, 3'd0, 3'd0, 1'b1, 32'h40, COND_NONE, 32'd0);
        memop("t4 str", 1'b0, 3'd0, 3'd5, 3'd1, 32'd2, 0, 32'd0);
        check("t4 str addr", mem_addr, 32'h48);
        memop("t4 ldr", 1'b1, 3'd6, 3'd5, 3'd0, 32'd2, 3, 32'hDEAD_BEEF);
        dbg_sel = 3'd6; #1;
        check("t4 r6", dbg_data, 32'hDEAD_BEEF);

        // Randomized mix of all legal bundle kinds.
        for (int it = 0; it < 300; it++) begin
            int kind;
            logic [31:0] rn;
            kind = $urandom_range(0, 9);
            rn = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
            if (kind < 6) begin
                op("rnd alu", alu_ops[kind], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), rn, COND_NONE, 32'd0);
            end else if (kind < 8) begin
                op("rnd br", UOP_NOP, 3'($urandom_range(0, 7)), 3'd0, 3'd0, 1'b1, rn,
                   4'($urandom_range(0, 15)), $urandom() & 32'hFFFF_FFFE);
            end else begin
                memop("rnd mem", kind == 9, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), rn, $urandom_range(0, TMO - 1), $urandom());
            end
        end
        check_regs("rnd end");

        // Undefined instruction traps with no side effects.
        set_bundle(UOP_MOV, 4'd1, 4'd0, 4'd0, 1'b1, 32'h99, COND_NONE, 32'd0);
        explose = 1'b1;
        pulse();
        explose = 1'b0;
        check("t5 trap", 32'(trap), 32'd1);
        check("t5 ready", 32'(in_ready), 32'd0);
        check("t5 retire", 32'(retire), 32'd0);
        set_bundle(UOP_MOV, 4'd2, 4'd0, 4'd0, 1'b1, 32'd123, COND_NONE, 32'd0);
        pulse();
        pulse();
        check("t5 ign retire", 32'(retire), 32'd0);
        check("t5 sticky", 32'(trap), 32'd1);
        check_regs("t5 kept");
        do_reset();
        check("t5 clr trap", 32'(trap), 32'd0);
        check("t5 clr ready", 32'(in_ready), 32'd1);

        // Reset while a load is outstanding; the late ack must be dropped.
        op("t6 mov", UOP_MOV, 3'd5, 3'd0, 3'd0, 1'b1, 32'h10, COND_NONE, 32'd0);
        set_bundle(UOP_LDR, 4'd3, 4'd5, 4'd0, 1'b1, 32'd1, COND_NONE, 32'd0);
        pulse();
        check("t6 req", 32'(mem_req), 32'd1);
        do_reset();
        check("t6 rst req", 32'(mem_req), 32'd0);
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("t6 late retire", 32'(retire), 32'd0);
        check("t6 late ready", 32'(in_ready), 32'd1);
        check("t6 late req", 32'(mem_req), 32'd0);
        check_regs("t6 rst");

        // Memory timeout with no ack.
        set_bundle(UOP_STR, 4'd0, 4'd1, 4'd2, 1'b0, 32'd7, COND_NONE, 32'd0);
        pulse();
        check("t6 to req0", 32'(mem_req), 32'd1);
        for (int k = 1; k < int'(TMO); k++) begin
            @(posedge clk); #1;
            check("t6 to req", 32'(mem_req), 32'd1);
            check("t6 to notrap", 32'(trap), 32'd0);
        end
        @(posedge clk); #1;
        check("t6 to trap", 32'(trap), 32'd1);
        check("t6 to req low", 32'(mem_req), 32'd0);
        check("t6 to retire", 32'(retire), 32'd0);
        do_reset();

        // Unknown uop and out-of-range register select both trap.
        set_bundle(5'd3, 4'd1, 4'd0, 4'd0, 1'b1, 32'd1, COND_NONE, 32'd0);
        pulse();
        check("bad uop trap", 32'(trap), 32'd1);
        check("bad uop retire", 32'(retire), 32'd0);
        do_reset();
        set_bundle(UOP_MOV, 4'd9, 4'd0, 4'd0, 1'b1, 32'h55, COND_NONE, 32'd0);
        pulse();
        check("bad sel trap", 32'(trap), 32'd1);
        check_regs("bad sel");
        do_reset();
        check("final ready", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
